// File: rtl/condlogic_banked.sv
// Condition unit with NBANK banked NZCV flag sets, a delayed CondEx pipe feeding PCWrite,
// and an IT-block sequencer that overrides Cond for up to IT_MAX instructions.
module condlogic_banked #(
  parameter int NBANK         = 2,
  parameter int CONDEX_STAGES = 1,
  parameter int IT_MAX        = 4,
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1,
  localparam int LW = $clog2(IT_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic [BW-1:0]     BankSel,
  input  logic              PCS,
  input  logic              NextPC,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              ITStart,
  input  logic [3:0]        ITCond,
  input  logic [LW-1:0]     ITLen,
  input  logic [IT_MAX-1:0] ITThen,
  input  logic              InstrDone,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic [3:0]        Flags,
  output logic              ITActive,
  output logic              ITErr
);

  typedef enum logic {IDLE, ACTIVE} it_state_t;

  logic [3:0]               bank_q [NBANK];
  logic [3:0]               cur_flags;
  logic [3:0]               eff_cond;
  logic [1:0]               flag_write;
  logic [CONDEX_STAGES-1:0] pipe_q;
  logic                     condex_dly;
  it_state_t                state_q;
  logic [LW-1:0]            cnt_q;
  logic [IT_MAX-1:0]        mask_q;
  logic                     err_q;
  logic                     len_ok;
  logic                     n_f, z_f, c_f, v_f;

  // Out-of-range bank selects read as all-zero flags.
  always_comb begin
    cur_flags = 4'b0000;
    for (int i = 0; i < NBANK; i++) begin
      if (BankSel == BW'(i)) cur_flags = bank_q[i];
    end
  end

  assign {n_f, z_f, c_f, v_f} = cur_flags;
  assign eff_cond = (state_q == ACTIVE) ? (mask_q[0] ? ITCond : (ITCond ^ 4'b0001)) : Cond;

  always_comb begin
    CondEx = 1'b0;
    case (eff_cond)
      4'b0000: CondEx = z_f;
      4'b0001: CondEx = ~z_f;
      4'b0010: CondEx = c_f;
      4'b0011: CondEx = ~c_f;
      4'b0100: CondEx = n_f;
      4'b0101: CondEx = ~n_f;
      4'b0110: CondEx = v_f;
      4'b0111: CondEx = ~v_f;
      4'b1000: CondEx = c_f & ~z_f;
      4'b1001: CondEx = ~c_f | z_f;
      4'b1010: CondEx = (n_f == v_f);
      4'b1011: CondEx = (n_f != v_f);
      4'b1100: CondEx = ~z_f & (n_f == v_f);
      4'b1101: CondEx = z_f | (n_f != v_f);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  assign flag_write = FlagW & {2{CondEx}};

  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      always_ff @(posedge clk) begin
        if (reset) begin
          bank_q[gi] <= 4'b0000;
        end else if (BankSel == BW'(gi)) begin
          if (flag_write[1]) bank_q[gi][3:2] <= ALUFlags[3:2];
          if (flag_write[0]) bank_q[gi][1:0] <= ALUFlags[1:0];
        end
      end
    end

    if (CONDEX_STAGES == 1) begin : g_pipe_one
      always_ff @(posedge clk) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= CondEx;
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= {pipe_q[CONDEX_STAGES-2:0], CondEx};
      end
    end
  endgenerate

  assign condex_dly = pipe_q[CONDEX_STAGES-1];
  assign len_ok     = (ITLen != '0) && (ITLen <= LW'(IT_MAX));

  // InstrDone alongside an accepted ITStart belongs to the IT instruction itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= ITStart & ((state_q == ACTIVE) | ~len_ok);
      case (state_q)
        IDLE: begin
          if (ITStart && len_ok) begin
            cnt_q   <= ITLen;
            mask_q  <= ITThen;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (InstrDone) begin
            mask_q <= mask_q >> 1;
            cnt_q  <= cnt_q - LW'(1);
            if (cnt_q == LW'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PCWrite  = (PCS & condex_dly) | NextPC;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;
  assign Flags    = cur_flags;
  assign ITActive = (state_q == ACTIVE);
  assign ITErr    = err_q;

endmodule

// File: tb/tb_condlogic_banked.sv
// Bench for condlogic_banked: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a queue-based behavioural model.
module tb_condlogic_banked;

  localparam int STAGES = 2;

  logic       clk;
  logic       reset;
  logic [3:0] Cond, ALUFlags, ITCond, ITThen;
  logic [1:0] FlagW;
  logic [0:0] BankSel;
  logic [2:0] ITLen;
  logic       PCS, NextPC, RegW, MemW, ITStart, InstrDone;
  logic       PCWrite, RegWrite, MemWrite, CondEx, ITActive, ITErr;
  logic [3:0] Flags;

  int total = 0;
  int bad   = 0;

  condlogic_banked #(.NBANK(2), .CONDEX_STAGES(STAGES), .IT_MAX(4)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .BankSel(BankSel), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITThen(ITThen),
    .InstrDone(InstrDone), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .Flags(Flags), .ITActive(ITActive), .ITErr(ITErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition as base test (by cond[3:1]) optionally inverted by cond[0].
  function automatic bit eval_cond(bit [3:0] c, bit [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    if (c == 4'b1110) return 1'b1;
    return base ^ c[0];
  endfunction

  // Behavioural model: flag banks, CondEx history queue, queue of pending IT then-bits.
  bit [3:0] m_bank [2];
  bit       m_hist [$];
  bit       m_then [$];
  bit       m_err;
  bit       m_valid = 1'b0;

  always @(negedge clk) begin
    bit [3:0] f, ec;
    bit       act, cx, dly, len_ok;
    if (m_valid) begin
      f   = m_bank[BankSel];
      act = (m_then.size() > 0);
      ec  = act ? (m_then[0] ? ITCond : (ITCond ^ 4'b0001)) : Cond;
      cx  = eval_cond(ec, f);
      dly = m_hist[0];
      chk("m_flags",    Flags,              f);
      chk("m_condex",   4'(CondEx),         4'(cx));
      chk("m_regwrite", 4'(RegWrite),       4'(RegW & cx));
      chk("m_memwrite", 4'(MemWrite),       4'(MemW & cx));
      chk("m_pcwrite",  4'(PCWrite),        4'((PCS & dly) | NextPC));
      chk("m_itactive", 4'(ITActive),       4'(act));
      chk("m_iterr",    4'(ITErr),          4'(m_err));
      if (!reset) begin
        len_ok = (ITLen != 3'd0) && (ITLen <= 3'd4);
        m_err  = ITStart && (act || !len_ok);
        if (!act && ITStart && len_ok) begin
          for (int i = 0; i < int'(ITLen); i++) m_then.push_back(ITThen[i]);
        end else if (act && InstrDone) begin
          void'(m_then.pop_front());
        end
        if (cx && FlagW[1]) m_bank[BankSel][3:2] = ALUFlags[3:2];
        if (cx && FlagW[0]) m_bank[BankSel][1:0] = ALUFlags[1:0];
        void'(m_hist.pop_front());
        m_hist.push_back(cx);
      end
    end
    if (reset) begin
      m_bank[0] = 4'b0000;
      m_bank[1] = 4'b0000;
      m_hist.delete();
      for (int i = 0; i < STAGES; i++) m_hist.push_back(1'b0);
      m_then.delete();
      m_err   = 1'b0;
      m_valid = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    Cond = 4'b1111; ALUFlags = 4'b0; FlagW = 2'b0; BankSel = 1'b0; PCS = 1'b0;
    NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; ITStart = 1'b0; ITCond = 4'b0;
    ITLen = 3'd0; ITThen = 4'b0; InstrDone = 1'b0;
  endtask

  initial begin
    clear();
    reset = 1'b1;
    tick(); tick();
    // Reset state and basic conditions on bank0 with Z=0
    reset = 1'b0; Cond = 4'b0000; RegW = 1'b1;
    settle();
    chk("rst_flags",   Flags,          4'b0000);
    chk("rst_itact",   4'(ITActive),   4'd0);
    chk("rst_iterr",   4'(ITErr),      4'd0);
    chk("rst_pcwrite", 4'(PCWrite),    4'd0);
    chk("eq_z0_regw",  4'(RegWrite),   4'd0);
    tick(); Cond = 4'b1110; settle();
    chk("al_regw", 4'(RegWrite), 4'd1);
    tick(); Cond = 4'b1111; settle();
    chk("nv_regw", 4'(RegWrite), 4'd0);
    // Flag write to bank0, other bank untouched
    tick(); FlagW = 2'b11; ALUFlags = 4'b0100; Cond = 4'b1110; settle();
    chk("flag_same_cycle", Flags, 4'b0000);
    tick(); FlagW = 2'b00; Cond = 4'b0000; settle();
    chk("flag_bank0",   Flags,        4'b0100);
    chk("eq_bank0",     4'(CondEx),   4'd1);
    tick(); BankSel = 1'b1; settle();
    chk("flag_bank1",   Flags,        4'b0000);
    chk("eq_bank1",     4'(CondEx),   4'd0);
    // CondEx pipe: two-cycle delay to PCWrite
    tick(); BankSel = 1'b0; PCS = 1'b1; Cond = 4'b1111;
    tick();
    tick(); Cond = 4'b1110; settle();
    chk("pc_t0", 4'(PCWrite), 4'd0);
    tick(); Cond = 4'b1111; settle();
    chk("pc_t1", 4'(PCWrite), 4'd0);
    tick(); settle();
    chk("pc_t2", 4'(PCWrite), 4'd1);
    tick(); settle();
    chk("pc_t3", 4'(PCWrite), 4'd0);
    tick(); NextPC = 1'b1; settle();
    chk("pc_nextpc", 4'(PCWrite), 4'd1);
    // IT block EQ,NE,EQ with Z=1 on bank0
    tick(); NextPC = 1'b0; PCS = 1'b0;
    ITStart = 1'b1; ITCond = 4'b0000; ITLen = 3'd3; ITThen = 4'b0101; InstrDone = 1'b1;
    settle();
    chk("it_start_idle", 4'(ITActive), 4'd0);
    tick(); ITStart = 1'b0; settle();
    chk("it_active", 4'(ITActive), 4'd1);
    chk("it_slot0",  4'(CondEx),   4'd1);
    tick(); settle();
    chk("it_slot1",  4'(CondEx),   4'd0);
    tick(); settle();
    chk("it_slot2",  4'(CondEx),   4'd1);
    tick(); InstrDone = 1'b0; settle();
    chk("it_done",   4'(ITActive), 4'd0);
    chk("it_cond_back", 4'(CondEx), 4'd0);
    // Rejected ITStart: zero length, then while active
    tick(); ITStart = 1'b1; ITLen = 3'd0; settle();
    tick(); ITStart = 1'b0; settle();
    chk("err_len0",      4'(ITErr),    4'd1);
    chk("err_len0_idle", 4'(ITActive), 4'd0);
    tick(); settle();
    chk("err_pulse_end", 4'(ITErr), 4'd0);
    tick(); ITStart = 1'b1; ITLen = 3'd2; ITThen = 4'b0011; settle();
    tick(); ITLen = 3'd4; settle();
    chk("err2_active", 4'(ITActive), 4'd1);
    tick(); ITStart = 1'b0; InstrDone = 1'b1; settle();
    chk("err_busy",       4'(ITErr),    4'd1);
    chk("err_busy_act",   4'(ITActive), 4'd1);
    tick(); settle();
    chk("cnt_kept",       4'(ITActive), 4'd1);
    tick(); InstrDone = 1'b0; settle();
    chk("cnt_expired",    4'(ITActive), 4'd0);
    // Reset in the middle of an IT block with nonzero flags
    tick(); FlagW = 2'b11; ALUFlags = 4'b1111; Cond = 4'b1110; BankSel = 1'b0; settle();
    tick(); FlagW = 2'b00; ITStart = 1'b1; ITLen = 3'd4; ITThen = 4'b1111;
    ITCond = 4'b1110; PCS = 1'b1; settle();
    tick(); ITStart = 1'b0; settle();
    chk("mid_active", 4'(ITActive), 4'd1);
    chk("mid_flags",  Flags,        4'b1111);
    tick(); reset = 1'b1; settle();
    tick(); reset = 1'b0; settle();
    chk("abort_itact", 4'(ITActive), 4'd0);
    chk("abort_flags", Flags,        4'b0000);
    chk("abort_pcw",   4'(PCWrite),  4'd0);
    // Random phase, model checks every cycle
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset     = ($urandom_range(0, 149) == 0);
      Cond      = 4'($urandom_range(0, 15));
      ALUFlags  = 4'($urandom_range(0, 15));
      FlagW     = 2'($urandom_range(0, 3));
      BankSel   = 1'($urandom_range(0, 1));
      PCS       = 1'($urandom_range(0, 1));
      NextPC    = ($urandom_range(0, 5) == 0);
      RegW      = 1'($urandom_range(0, 1));
      MemW      = 1'($urandom_range(0, 1));
      ITStart   = ($urandom_range(0, 7) == 0);
      ITCond    = 4'($urandom_range(0, 15));
      ITLen     = 3'($urandom_range(0, 6));
      ITThen    = 4'($urandom_range(0, 15));
      InstrDone = 1'($urandom_range(0, 1));
    end
    tick();
    clear();
    reset = 1'b0;
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
